voice_mixer: RTL and testbench
==============================

VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter NVOICES, default 3, number of mixed voices; legal range 1..8.
REQ-002 SHALL have port clk24  input  1  audio clock (24.576/24.75 MHz); all logic on rising edge.
REQ-003 SHALL have port rstn  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port ready  input  1  frame request pulse from i2s stage.
REQ-005 SHALL have port voices  input  NVOICES*16  signed voice samples; voice k at [16k+15:16k].
REQ-006 SHALL have port gain_l  input  NVOICES*8  unsigned left gain per voice, Q1.7 (128 = unity).
REQ-007 SHALL have port gain_r  input  NVOICES*8  unsigned right gain per voice, Q1.7.
REQ-008 SHALL have port sound  output  32  stereo frame to i2s: [31:16] left, [15:0] right, signed.
REQ-009 SHALL have port sample_valid  output  1  one-cycle pulse when sound updates.
REQ-010 SHALL have port clip  output  1  high for the frame if either channel saturated.
REQ-011 SHALL have port overrun  output  1  sticky: ready arrived while busy.

Function
REQ-012 SHALL use an FSM with states IDLE, LATCH, ACCUM, SAT, OUT.
REQ-013 IDLE: ready=1 sampled -> LATCH; ready=0 -> stay.
REQ-014 LATCH (1 cycle): snapshot voices, gain_l, gain_r into internal registers; clear both accumulators; voice index := 0.
REQ-015 ACCUM (NVOICES cycles): per cycle add voice[idx]*gain_l[idx] to acc_l and voice[idx]*gain_r[idx] to acc_r; idx increments; after idx=NVOICES-1 -> SAT.
REQ-016 SHALL use one signed 16x9 multiplier per channel (gain zero-extended), time-multiplexed across voices.
REQ-017 Accumulators SHALL be 28-bit signed; no overflow possible for NVOICES<=8.
REQ-018 SAT (1 cycle): result = acc >>> 7 (arithmetic), reduced to 16 bits per REQ-027/028.
REQ-019 OUT (1 cycle): register sound and clip, pulse sample_valid, -> IDLE.
REQ-020 Latency: sound updates on edge NVOICES+3 after the edge that sampled ready (6 for NVOICES=3).
REQ-021 sound and clip SHALL hold their value between updates; input changes after LATCH SHALL not affect the frame.
REQ-022 ready sampled high in any state other than IDLE SHALL be ignored and set overrun; the frame in progress completes unchanged.
REQ-023 ready held high continuously SHALL start a new frame on each return to IDLE (IDLE sees ready=1 -> LATCH).

Reset
REQ-024 rstn=0 at a clock edge SHALL force IDLE, sound=0, sample_valid=0, clip=0, overrun=0, accumulators=0.
REQ-025 Reset mid-frame SHALL abort the frame with no sample_valid pulse; the next ready after release starts a fresh frame.
REQ-026 overrun SHALL clear only on reset.

Configuration
REQ-027 With MIXER_SATURATE_EN defined: each channel clamped to [-32768, 32767]; clip=1 if either channel clamped.
REQ-028 Without MIXER_SATURATE_EN: each channel = low 16 bits of shifted result (two's-complement wrap); clip tied 0.

Verification
REQ-029 rstn=0 for 2 cycles -> sound=0, sample_valid=0, clip=0, overrun=0, FSM IDLE.
REQ-030 NVOICES=3, voice0=1000, gain_l0=128, gain_r0=64, other voices 0; one ready pulse -> 6 cycles later sound={16'd1000,16'd500}, sample_valid one cycle, clip=0.
REQ-031 All voices 32767, all gains 128 -> with MIXER_SATURATE_EN sound={16'h7FFF,16'h7FFF}, clip=1; without: sound={16'h7FFD,16'h7FFD}, clip=0.
REQ-032 voice0=-32768, gain_l0=gain_r0=255, others 0 -> with MIXER_SATURATE_EN sound={16'h8000,16'h8000}, clip=1; without: low 16 bits of -65280 = 16'h0100 per channel.
REQ-033 Second ready pulse 2 cycles after first -> overrun=1 and stays 1; first frame result unchanged; exactly one sample_valid.
REQ-034 rstn=0 during ACCUM -> no sample_valid, sound=0; after release a ready pulse yields the correct frame with the REQ-020 latency.

Source files
------------

// File: rtl/voice_mixer.sv
// Multi-voice stereo mixer: time-multiplexed multiply-accumulate per frame.
// Define MIXER_SATURATE_EN to clamp each channel to 16 bits and drive clip.
module voice_mixer #(
  parameter int NVOICES = 3
) (
  input  logic                   clk24,
  input  logic                   rstn,
  input  logic                   ready,
  input  logic [NVOICES*16-1:0]  voices,
  input  logic [NVOICES*8-1:0]   gain_l,
  input  logic [NVOICES*8-1:0]   gain_r,
  output logic [31:0]            sound,
  output logic                   sample_valid,
  output logic                   clip,
  output logic                   overrun
);

  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NVOICES - 1);

  typedef enum logic [2:0] {
    IDLE, LATCH, ACCUM, SAT, OUT
  } state_t;

  state_t             state_q;
  logic signed [15:0] v_q  [NVOICES];
  logic [7:0]         gl_q [NVOICES];
  logic [7:0]         gr_q [NVOICES];
  logic [IW-1:0]      idx_q;
  logic signed [27:0] acc_l_q, acc_r_q;
  logic [31:0]        res_q;
  logic               res_clip_q;
  logic [31:0]        sound_q;
  logic               sv_q, clip_q, ovr_q;

  logic signed [24:0] vx, glx, grx, prod_l, prod_r;
  logic signed [20:0] sh_l, sh_r;
  logic [15:0]        ch_l_d, ch_r_d;
  logic               cl_l_d, cl_r_d;
  logic               unused_bits;

  // One shared multiplier per channel; gain is zero-extended to stay positive
  assign vx     = {{9{v_q[idx_q][15]}}, v_q[idx_q]};
  assign glx    = {17'd0, gl_q[idx_q]};
  assign grx    = {17'd0, gr_q[idx_q]};
  assign prod_l = vx * glx;
  assign prod_r = vx * grx;

  assign sh_l = acc_l_q[27:7];
  assign sh_r = acc_r_q[27:7];

`ifdef MIXER_SATURATE_EN
  always_comb begin
    ch_l_d = sh_l[15:0];
    cl_l_d = 1'b0;
    ch_r_d = sh_r[15:0];
    cl_r_d = 1'b0;
    if (sh_l > 21'sd32767) begin
      ch_l_d = 16'h7FFF; cl_l_d = 1'b1;
    end else if (sh_l < -21'sd32768) begin
      ch_l_d = 16'h8000; cl_l_d = 1'b1;
    end
    if (sh_r > 21'sd32767) begin
      ch_r_d = 16'h7FFF; cl_r_d = 1'b1;
    end else if (sh_r < -21'sd32768) begin
      ch_r_d = 16'h8000; cl_r_d = 1'b1;
    end
  end
  assign unused_bits = ^{acc_l_q[6:0], acc_r_q[6:0]};
`else
  assign ch_l_d = sh_l[15:0];
  assign ch_r_d = sh_r[15:0];
  assign cl_l_d = 1'b0;
  assign cl_r_d = 1'b0;
  assign unused_bits = ^{acc_l_q[6:0], acc_r_q[6:0],
                         sh_l[20:16], sh_r[20:16]};
`endif

  always_ff @(posedge clk24) begin
    if (!rstn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      res_q      <= '0;
      res_clip_q <= 1'b0;
      sound_q    <= '0;
      sv_q       <= 1'b0;
      clip_q     <= 1'b0;
      ovr_q      <= 1'b0;
      for (int k = 0; k < NVOICES; k++) begin
        v_q[k]  <= '0;
        gl_q[k] <= '0;
        gr_q[k] <= '0;
      end
    end else begin
      sv_q <= 1'b0;
      if (ready && state_q != IDLE) ovr_q <= 1'b1;
      unique case (state_q)
        IDLE: if (ready) state_q <= LATCH;
        LATCH: begin
          for (int k = 0; k < NVOICES; k++) begin
            v_q[k]  <= voices[16*k +: 16];
            gl_q[k] <= gain_l[8*k +: 8];
            gr_q[k] <= gain_r[8*k +: 8];
          end
          acc_l_q <= '0;
          acc_r_q <= '0;
          idx_q   <= '0;
          state_q <= ACCUM;
        end
        ACCUM: begin
          acc_l_q <= acc_l_q + {{3{prod_l[24]}}, prod_l};
          acc_r_q <= acc_r_q + {{3{prod_r[24]}}, prod_r};
          if (idx_q == LAST) state_q <= SAT;
          else idx_q <= idx_q + 1'b1;
        end
        SAT: begin
          res_q      <= {ch_l_d, ch_r_d};
          res_clip_q <= cl_l_d | cl_r_d;
          state_q    <= OUT;
        end
        OUT: begin
          sound_q <= res_q;
          clip_q  <= res_clip_q;
          sv_q    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sound        = sound_q;
  assign sample_valid = sv_q;
  assign clip         = clip_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: directed frames, overrun, reset abort.
// Expectations follow MIXER_SATURATE_EN when the same define is given.
module tb_voice_mixer;

  localparam int N = 3;

  logic          clk24 = 1'b0;
  logic          rstn;
  logic          ready;
  logic [N*16-1:0] voices;
  logic [N*8-1:0]  gain_l, gain_r;
  logic [31:0]   sound;
  logic          sample_valid, clip, overrun;

  voice_mixer #(.NVOICES(N)) dut (
    .clk24(clk24), .rstn(rstn), .ready(ready),
    .voices(voices), .gain_l(gain_l), .gain_r(gain_r),
    .sound(sound), .sample_valid(sample_valid),
    .clip(clip), .overrun(overrun)
  );

  always #5 clk24 = ~clk24;

  int cyc = 0;
  always @(posedge clk24) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] snd;
    logic        clp;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Monitor: every sample_valid pops one expected frame
  always @(negedge clk24) begin
    if (sample_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid got sound %h expected none (cycle %0d)",
                 sound, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sound", sound, e.snd);
        chk("clip", {31'd0, clip}, {31'd0, e.clp});
        chk("latency", 32'(cyc), 32'(e.at));
      end
    end
  end

  localparam logic [47:0] V_A   = {16'd0, 16'd0, 16'd1000};
  localparam logic [23:0] GL_A  = {8'd0, 8'd0, 8'd128};
  localparam logic [23:0] GR_A  = {8'd0, 8'd0, 8'd64};
  localparam logic [31:0] S_A   = {16'd1000, 16'd500};
  localparam logic [47:0] V_B   = {16'h7FFF, 16'h7FFF, 16'h7FFF};
  localparam logic [23:0] G_B   = {8'd128, 8'd128, 8'd128};
  localparam logic [47:0] V_C   = {16'd0, 16'd0, 16'h8000};
  localparam logic [23:0] G_C   = {8'd0, 8'd0, 8'd255};
  localparam logic [47:0] V_M   = {16'd300, 16'hFF38, 16'd100};
  localparam logic [23:0] GL_M  = {8'd32, 8'd64, 8'd128};
  localparam logic [23:0] GR_M  = {8'd128, 8'd255, 8'd0};
  localparam logic [31:0] S_M   = {16'd75, 16'hFF9D};
`ifdef MIXER_SATURATE_EN
  localparam logic [31:0] S_B = 32'h7FFF_7FFF;
  localparam logic        C_B = 1'b1;
  localparam logic [31:0] S_C = 32'h8000_8000;
  localparam logic        C_C = 1'b1;
`else
  localparam logic [31:0] S_B = 32'h7FFD_7FFD;
  localparam logic        C_B = 1'b0;
  localparam logic [31:0] S_C = 32'h0100_0100;
  localparam logic        C_C = 1'b0;
`endif

  task automatic run_frame(input logic [47:0] v, input logic [23:0] gl,
                           input logic [23:0] gr, input logic [31:0] es,
                           input logic ec, input bit scramble);
    @(negedge clk24);
    voices = v; gain_l = gl; gain_r = gr; ready = 1'b1;
    exp_q.push_back('{es, ec, cyc + 1 + N + 3});
    @(negedge clk24);
    ready = 1'b0;
    @(negedge clk24);
    if (scramble) begin
      voices = 48'h7FFF_8000_1234;
      gain_l = 24'hFF_FF_FF;
      gain_r = 24'h01_02_03;
    end
    repeat (N + 3) @(negedge clk24);
  endtask

  initial begin
    rstn = 1'b0; ready = 1'b0;
    voices = '0; gain_l = '0; gain_r = '0;
    repeat (2) @(negedge clk24);
    chk("rst_sound", sound, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_clip", {31'd0, clip}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk24);

    run_frame(V_A, GL_A, GR_A, S_A, 1'b0, 1'b0);
    chk("hold_sound", sound, S_A);
    run_frame(V_B, G_B, G_B, S_B, C_B, 1'b0);
    run_frame(V_C, G_C, G_C, S_C, C_C, 1'b0);
    run_frame(V_M, GL_M, GR_M, S_M, 1'b0, 1'b0);
    run_frame(V_A, GL_A, GR_A, S_A, 1'b0, 1'b1);
    chk("no_overrun", {31'd0, overrun}, 32'd0);

    // Second ready lands two cycles into the frame
    @(negedge clk24);
    voices = V_M; gain_l = GL_M; gain_r = GR_M; ready = 1'b1;
    exp_q.push_back('{S_M, 1'b0, cyc + 1 + N + 3});
    @(negedge clk24); ready = 1'b0;
    @(negedge clk24); ready = 1'b1;
    @(negedge clk24); ready = 1'b0;
    repeat (N + 3) @(negedge clk24);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    run_frame(V_A, GL_A, GR_A, S_A, 1'b0, 1'b0);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset while accumulating aborts the frame
    @(negedge clk24);
    voices = V_B; gain_l = G_B; gain_r = G_B; ready = 1'b1;
    @(negedge clk24); ready = 1'b0;
    @(negedge clk24); rstn = 1'b0;
    repeat (2) @(negedge clk24);
    chk("abort_sound", sound, 32'd0);
    chk("abort_valid", {31'd0, sample_valid}, 32'd0);
    chk("abort_clip", {31'd0, clip}, 32'd0);
    chk("abort_overrun", {31'd0, overrun}, 32'd0);
    rstn = 1'b1;
    repeat (N + 5) @(negedge clk24);
    chk("post_abort_sound", sound, 32'd0);
    run_frame(V_M, GL_M, GR_M, S_M, 1'b0, 1'b0);

    // ready held high: back-to-back frames
    @(negedge clk24);
    voices = V_A; gain_l = GL_A; gain_r = GR_A; ready = 1'b1;
    exp_q.push_back('{S_A, 1'b0, cyc + N + 4});
    exp_q.push_back('{S_A, 1'b0, cyc + 2 * N + 8});
    repeat (N + 6) @(negedge clk24);
    ready = 1'b0;

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk24);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending frames expected 0", exp_q.size());
    end
    repeat (4) @(negedge clk24);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
